cn_minsum_sched: RTL and testbench
==================================

Name: cn_minsum_sched

Overview:
- Serial check-node scheduler for the min-sum LDPC decoder.
- Accepts one row of variable-to-check messages per cycle over a valid/ready stream, in sign-magnitude form.
- Sequences the min / second-min compare across the whole row, tracking the index of the minimum and the XOR of all signs.
- Presents one row result per row to the check-to-variable message generator.

Parameters:
- PREC, 5, magnitude width in bits (matches the comparator prec).
- MAX_DEG, 8, maximum row degree; a row is force-terminated at this count.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= MAX_DEG.
- OFFSET, 1, offset subtracted when CN_OFFSET_EN is defined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input message valid.
- in_ready  out  1  block can accept an input message.
- in_sign  in  1  message sign (1 = negative).
- in_mag  in  PREC  message magnitude.
- in_last  in  1  marks the final message of the row.
- out_valid  out  1  row result valid.
- out_ready  in  1  downstream accepts the result.
- out_min  out  PREC  row minimum magnitude.
- out_sec_min  out  PREC  row second-minimum magnitude.
- out_min_idx  out  IDX_W  position in the row (0-based) of out_min.
- out_sign  out  1  XOR of all signs in the row.
- out_deg  out  IDX_W+1  number of messages accepted in the row.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - out_min and out_sec_min = all ones; out_min_idx=0, out_sign=0, out_deg=0.
  - Running registers are reset to the same values.
  - Asserting reset mid-row or while HOLD discards all partial state and any pending result.
- States: IDLE, ACCUM, HOLD.
  - IDLE: running min and sec_min = all ones, count=0, sign=0.
  - ACCUM: the row is in progress.
  - HOLD: the result is presented.
- Handshake rules:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
  - In IDLE, an accepted beat moves the FSM to ACCUM, or directly to HOLD if it ends the row.
- Per-beat update (count = k before the beat):
  - If in_mag <= min: sec_min <= min; min <= in_mag; min_idx <= k. A tie goes to the newest beat.
  - Else if in_mag < sec_min: sec_min <= in_mag.
  - Otherwise min and sec_min are unchanged.
  - sign <= sign ^ in_sign; count <= k+1.
- Row end: the accepted beat has in_last=1, or k = MAX_DEG-1 (force-terminate; in_last is ignored).
  - The FSM enters HOLD the next cycle with the outputs registered.
  - Latency: out_valid is high exactly 1 cycle after the last beat is accepted.
- HOLD:
  - Outputs stay stable while out_valid && !out_ready.
  - On out_ready: out_valid drops and the FSM returns to IDLE with the running registers reinitialised.
  - in_ready is 1 the following cycle, giving one bubble cycle per row.
- Single-beat row: out_min = in_mag, out_sec_min = all ones, out_min_idx=0, out_deg=1.
- All magnitude compares are unsigned, PREC bits; no widening.
- out_deg saturates naturally at MAX_DEG because of force-termination.

Optional Feature:
- Macro: CN_OFFSET_EN.
- Defined: offset min-sum is applied on entry to HOLD.
  - out_min = max(min - OFFSET, 0); out_sec_min = max(sec_min - OFFSET, 0).
  - Saturating subtract; the all-ones sec_min of a single-beat row is also offset.
- Undefined: raw min and sec_min are output; the OFFSET parameter is unused.

Test Plan:
- Row mags 7,3,9,3 with signs 0,1,0,0, in_last on the 4th beat, out_ready=1.
  - Expect: out_min=3, out_sec_min=3, out_min_idx=3, out_sign=1, out_deg=4.
  - out_valid is high 1 cycle after the 4th accept.
- Single beat mag=12 with in_last → out_min=12, out_sec_min=31, out_min_idx=0, out_deg=1.
  - With CN_OFFSET_EN and OFFSET=1: 11 and 30.
- 9 beats with no in_last and MAX_DEG=8.
  - Row is force-terminated after beat 8 with out_deg=8.
  - The 9th beat is held off (in_ready=0 in HOLD) and starts the next row.
- out_ready held 0 for 5 cycles in HOLD.
  - Outputs are stable and in_ready=0 throughout.
  - Release → out_valid=0 next cycle, in_ready=1.
- rst pulsed after 2 of 4 beats, then a fresh row of mags 4,6.
  - Expect out_min=4, out_sec_min=6, out_min_idx=0, out_deg=2, with no residue from the aborted row.
- in_valid toggling 1,0,1,0 within a row (mags 5,2,8,last).
  - Only accepted beats count: out_min=2, out_sec_min=5, out_min_idx=1, out_deg=3.

Source files
------------

// File: rtl/cn_minsum_sched.sv
// Serial min-sum check-node scheduler: tracks min, second-min, min index and sign parity per row.
// Optional offset min-sum on the row result is built when CN_OFFSET_EN is defined.
module cn_minsum_sched #(
  parameter int PREC    = 5,
  parameter int MAX_DEG = 8,
  parameter int IDX_W   = 3,
  parameter int OFFSET  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [PREC-1:0]  in_mag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PREC-1:0]  out_min,
  output logic [PREC-1:0]  out_sec_min,
  output logic [IDX_W-1:0] out_min_idx,
  output logic             out_sign,
  output logic [IDX_W:0]   out_deg
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nxt;

  logic [PREC-1:0]  run_min, run_sec;
  logic [IDX_W-1:0] run_idx;
  logic             run_sign;
  logic [IDX_W:0]   run_cnt;

  logic             accept, row_end;
  logic [PREC-1:0]  nxt_min, nxt_sec;
  logic [IDX_W-1:0] nxt_idx;

  assign accept  = in_valid && in_ready;
  assign row_end = in_last || (run_cnt == (IDX_W+1)'(MAX_DEG-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = row_end ? HOLD : ACCUM;
      ACCUM:   if (accept && row_end) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  // Ties go to the newest beat, so the min moves into sec_min on equality.
  always_comb begin
    nxt_min = run_min;
    nxt_sec = run_sec;
    nxt_idx = run_idx;
    if (in_mag <= run_min) begin
      nxt_sec = run_min;
      nxt_min = in_mag;
      nxt_idx = run_cnt[IDX_W-1:0];
    end else if (in_mag < run_sec) begin
      nxt_sec = in_mag;
    end
  end

`ifdef CN_OFFSET_EN
  function automatic logic [PREC-1:0] apply_ofs(input logic [PREC-1:0] v);
    return (v > PREC'(OFFSET)) ? v - PREC'(OFFSET) : '0;
  endfunction
`else
  function automatic logic [PREC-1:0] apply_ofs(input logic [PREC-1:0] v);
    return v;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min     <= '1;
      run_sec     <= '1;
      run_idx     <= '0;
      run_sign    <= 1'b0;
      run_cnt     <= '0;
      out_min     <= '1;
      out_sec_min <= '1;
      out_min_idx <= '0;
      out_sign    <= 1'b0;
      out_deg     <= '0;
    end else if (accept) begin
      run_min  <= nxt_min;
      run_sec  <= nxt_sec;
      run_idx  <= nxt_idx;
      run_sign <= run_sign ^ in_sign;
      run_cnt  <= run_cnt + 1'b1;
      if (row_end) begin
        out_min     <= apply_ofs(nxt_min);
        out_sec_min <= apply_ofs(nxt_sec);
        out_min_idx <= nxt_idx;
        out_sign    <= run_sign ^ in_sign;
        out_deg     <= run_cnt + 1'b1;
      end
    end else if (state == HOLD && out_ready) begin
      run_min  <= '1;
      run_sec  <= '1;
      run_idx  <= '0;
      run_sign <= 1'b0;
      run_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_cn_minsum_sched.sv
// Directed bench for cn_minsum_sched; expected values are hand-computed per row.
// Build with CN_OFFSET_EN defined to check the offset min-sum variant.
module tb_cn_minsum_sched;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0, in_ready, in_sign = 0, in_last = 0;
  logic [4:0] in_mag = 0;
  logic       out_valid, out_ready = 0;
  logic [4:0] out_min, out_sec_min;
  logic [2:0] out_min_idx;
  logic       out_sign;
  logic [3:0] out_deg;
  int n_cmp = 0, n_bad = 0;

  cn_minsum_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mag(in_mag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_sec_min(out_sec_min), .out_min_idx(out_min_idx),
    .out_sign(out_sign), .out_deg(out_deg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ofs(input int v);
`ifdef CN_OFFSET_EN
    return (v > 1) ? v - 1 : 0;
`else
    return v;
`endif
  endfunction

  task automatic beat(input logic s, input logic [4:0] m, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_sign = s; in_mag = m; in_last = l;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) check_val("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 0; in_mag = 0; in_sign = 1; in_last = 1;
    @(posedge clk); #1;
    in_last = 0;
  endtask

  task automatic check_row(input string tag, input int mn, input int sec,
                           input int idx, input int sg, input int deg);
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_min"}, out_min, ofs(mn));
    check_val({tag, "_sec"}, out_sec_min, ofs(sec));
    check_val({tag, "_idx"}, out_min_idx, idx);
    check_val({tag, "_sign"}, out_sign, sg);
    check_val({tag, "_deg"}, out_deg, deg);
  endtask

  task automatic release_row(input string tag);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    check_val({tag, "_rel_valid"}, out_valid, 0);
    check_val({tag, "_rel_ready"}, in_ready, 1);
    out_ready = 0;
  endtask

  initial begin
    logic [4:0] m8 [8] = '{10, 12, 4, 15, 4, 9, 30, 6};
    logic       s8 [8] = '{1, 1, 1, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_val("rst_ready", in_ready, 1);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_min", out_min, 31);
    check_val("rst_sec", out_sec_min, 31);
    check_val("rst_idx", out_min_idx, 0);
    check_val("rst_sign", out_sign, 0);
    check_val("rst_deg", out_deg, 0);

    // row 7,3,9,3 with out_ready already high: one HOLD cycle
    out_ready = 1;
    beat(0, 7, 0); beat(1, 3, 0); beat(0, 9, 0); beat(0, 3, 1);
    check_row("row4", 3, 3, 3, 1, 4);
    @(posedge clk); #1;
    check_val("row4_drop", out_valid, 0);
    check_val("row4_ready", in_ready, 1);
    out_ready = 0;

    beat(0, 12, 1);
    check_row("single", 12, 31, 0, 0, 1);
    release_row("single");

    // force termination at MAX_DEG, then the 9th beat stalls through a 5-cycle hold
    for (int i = 0; i < 8; i++) beat(s8[i], m8[i], 0);
    check_row("force", 4, 4, 4, 1, 8);
    @(negedge clk);
    in_valid = 1; in_sign = 0; in_mag = 7; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("hold_ready", in_ready, 0);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_min", out_min, ofs(4));
      check_val("hold_deg", out_deg, 8);
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    check_val("hold_rel_valid", out_valid, 0);
    check_val("hold_rel_ready", in_ready, 1);
    out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    check_row("ninth", 7, 31, 0, 0, 1);
    release_row("ninth");

    // reset mid-row discards partial state
    beat(1, 1, 0); beat(1, 1, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
    check_val("abort_ready", in_ready, 1);
    check_val("abort_valid", out_valid, 0);
    check_val("abort_min", out_min, 31);
    check_val("abort_deg", out_deg, 0);
    beat(0, 4, 0); beat(0, 6, 1);
    check_row("fresh", 4, 6, 0, 0, 2);
    release_row("fresh");

    // in_valid gaps must not count as beats
    beat(0, 5, 0); gap(); beat(0, 2, 0); gap(); beat(0, 8, 1);
    check_row("gaps", 2, 5, 1, 0, 3);
    release_row("gaps");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
